// File: rtl/msg_uart_tx.sv
// Message UART transmitter: serialises a host-written character buffer on tx
// with a runtime frame format and baud divisor, one-shot or repeating.
module msg_uart_tx #(
  parameter int unsigned DIV_W     = 12,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
  input  logic                 cfg_repeat,
  input  logic [ADDR_W-1:0]    msg_last,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 start,
  input  logic                 stop_req,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    char_idx
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned SH_W  = DATA_BITS + 3;
  localparam int unsigned CNT_W = $clog2(DATA_BITS + 4);
  localparam logic [CNT_W-1:0] BASE_BITS = CNT_W'(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     baud_cnt;
  logic                 par_en_q, par_odd_q, two_stop_q, repeat_q;
  logic [ADDR_W-1:0]    last_q;
  logic                 stop_flag;
  logic [SH_W-1:0]      shreg;
  logic [CNT_W-1:0]     bits_left;
  logic [DATA_BITS-1:0] cur_char;
  logic                 par_bit;
  logic                 last_char;
  logic                 abort;

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    cur_char  = mem[char_idx];
    par_bit   = par_en_q ? (^cur_char ^ par_odd_q) : 1'b1;
    last_char = (char_idx == last_q);
    abort     = stop_flag | stop_req;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      char_idx   <= '0;
      stop_flag  <= 1'b0;
      baud_cnt   <= '0;
      bits_left  <= '0;
      shreg      <= '1;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      repeat_q   <= 1'b0;
      last_q     <= '0;
    end else begin
      done <= 1'b0;
      if (busy && stop_req) stop_flag <= 1'b1;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            busy       <= 1'b1;
            div_q      <= baud_div;
            par_en_q   <= cfg_parity_en;
            par_odd_q  <= cfg_parity_odd;
            two_stop_q <= cfg_two_stop;
            repeat_q   <= cfg_repeat;
            last_q     <= msg_last;
            char_idx   <= '0;
            stop_flag  <= stop_req;
            state      <= LOAD;
          end
        end
        LOAD: begin
          // Shift register holds everything after the start bit; unused
          // stop/parity slots are pre-filled with 1 so shifting in 1s is safe.
          tx        <= 1'b0;
          shreg     <= {2'b11, par_bit, cur_char};
          bits_left <= BASE_BITS + CNT_W'(par_en_q) + CNT_W'(two_stop_q);
          baud_cnt  <= '0;
          state     <= SEND;
        end
        SEND: begin
          if (baud_cnt != div_q) begin
            baud_cnt <= baud_cnt + DIV_W'(1);
          end else begin
            baud_cnt <= '0;
            if (bits_left != '0) begin
              tx        <= shreg[0];
              shreg     <= {1'b1, shreg[SH_W-1:1]};
              bits_left <= bits_left - CNT_W'(1);
            end else if (abort || (last_char && !repeat_q)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              stop_flag <= 1'b0;
              char_idx  <= '0;
            end else begin
              char_idx <= last_char ? '0 : char_idx + ADDR_W'(1);
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msg_uart_tx.sv
// Bench for msg_uart_tx: a timeline model of expected frames feeds queues that
// a negedge monitor consumes cycle by cycle; a DATA_BITS=5 instance is also checked.
module tb_msg_uart_tx;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [11:0]   bdiv;
  logic          pen, podd, two, rep;
  logic [AW-1:0] mlast;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start, stop_req;
  logic          tx, busy, done;
  logic [AW-1:0] cidx;

  logic [11:0]   bdiv5;
  logic [AW-1:0] mlast5;
  logic          wr5_en;
  logic [AW-1:0] wr5_addr;
  logic [4:0]    wr5_data;
  logic          start5;
  logic          tx5, busy5, done5;
  logic [AW-1:0] cidx5;

  msg_uart_tx #(.DIV_W(12), .DATA_BITS(DW), .ADDR_W(AW)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .baud_div(bdiv),
    .cfg_parity_en(pen), .cfg_parity_odd(podd), .cfg_two_stop(two), .cfg_repeat(rep),
    .msg_last(mlast), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop_req(stop_req),
    .tx(tx), .busy(busy), .done(done), .char_idx(cidx)
  );

  msg_uart_tx #(.DIV_W(12), .DATA_BITS(5), .ADDR_W(AW)) u_dut5 (
    .wb_clk_i(clk), .wb_rst_i(rst), .baud_div(bdiv5),
    .cfg_parity_en(1'b0), .cfg_parity_odd(1'b0), .cfg_two_stop(1'b0), .cfg_repeat(1'b0),
    .msg_last(mlast5), .wr_en(wr5_en), .wr_addr(wr5_addr), .wr_data(wr5_data),
    .start(start5), .stop_req(1'b0),
    .tx(tx5), .busy(busy5), .done(done5), .char_idx(cidx5)
  );

  typedef struct {
    int         start_cyc;
    int         nbits;
    int         per;
    logic [11:0] bits;
    int         idx;
  } frame_t;
  typedef struct {
    int lo;
    int hi;
  } win_t;

  int       cyc = 0;
  int       n_cmp = 0;
  int       n_bad = 0;
  bit       mon_en = 1'b0;
  int       flush_at = -1;
  logic [DW-1:0] mirror [16];
  frame_t   fq[$];
  int       done_q[$];
  win_t     bq[$];
  logic     e5q[$];
  int       e5_start = -1;
  int       e5_done = -1;
  int       bpos;
  bit       bexp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line timeline: frame k starts one clock after start is taken,
  // each frame is nb*(div+1) clocks followed by one idle-high gap clock.
  task automatic plan(input int c0, input int dv, input int pe, input int po, input int ts,
                      input int last, input int nframes, output int endc, output int last_s);
    int per, nb, s, idx, ones;
    frame_t fr;
    logic [DW-1:0] d;
    per = dv + 1;
    nb = 1 + DW + pe + 1 + ts;
    s = c0 + 1;
    idx = 0;
    last_s = s;
    for (int f = 0; f < nframes; f++) begin
      d = mirror[idx];
      ones = 0;
      fr.bits = '1;
      fr.bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) begin
        fr.bits[1+i] = d[i];
        ones += int'(d[i]);
      end
      if (pe != 0) fr.bits[1+DW] = (po != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      fr.start_cyc = s;
      fr.nbits = nb;
      fr.per = per;
      fr.idx = idx;
      fq.push_back(fr);
      last_s = s;
      s = s + nb * per + 1;
      idx = (idx == last) ? 0 : idx + 1;
    end
    endc = s - 1;
    done_q.push_back(endc);
    bq.push_back('{c0, endc});
  endtask

  always @(negedge clk) begin
    if (flush_at >= 0 && cyc >= flush_at) begin
      fq.delete();
      done_q.delete();
      bq.delete();
      flush_at = -1;
    end
    if (mon_en) begin
      while (fq.size() > 0 && cyc >= fq[0].start_cyc + fq[0].nbits * fq[0].per) fq.delete(0);
      if (fq.size() > 0 && cyc >= fq[0].start_cyc) begin
        bpos = (cyc - fq[0].start_cyc) / fq[0].per;
        chk("tx_bit", int'(tx), int'(fq[0].bits[bpos]));
        chk("char_idx", int'(cidx), fq[0].idx);
      end else begin
        chk("tx_idle", int'(tx), 1);
      end
      while (bq.size() > 0 && cyc >= bq[0].hi) bq.delete(0);
      bexp = (bq.size() > 0 && cyc >= bq[0].lo);
      chk("busy", int'(busy), int'(bexp));
      if (!bexp) chk("char_idx_idle", int'(cidx), 0);
      chk("done", int'(done), int'(done_q.size() > 0 && done_q[0] == cyc));
      while (done_q.size() > 0 && done_q[0] <= cyc) done_q.delete(0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (e5q.size() > 0 && cyc >= e5_start) chk("tx5_bit", int'(tx5), int'(e5q.pop_front()));
      else chk("tx5_idle", int'(tx5), 1);
      chk("done5", int'(done5), int'(cyc == e5_done));
    end
  end

  task automatic push5(input logic [4:0] d);
    e5q.push_back(1'b0);
    for (int i = 0; i < 5; i++) e5q.push_back(d[i]);
    e5q.push_back(1'b1);
  endtask

  task automatic wr_buf(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
    mirror[a] = d;
  endtask

  task automatic wr5(input int a, input logic [4:0] d);
    wr5_en = 1'b1;
    wr5_addr = 4'(a);
    wr5_data = d;
    tick(1);
    wr5_en = 1'b0;
  endtask

  task automatic run_msg(input int dv, input int pe, input int po, input int ts, input int rp,
                         input int last, input int nframes, input bit stop_mid,
                         input bit stop_now, input bit poke);
    int c0, endc, last_s, stop_at, nb;
    bdiv = 12'(dv);
    pen = pe[0];
    podd = po[0];
    two = ts[0];
    rep = rp[0];
    mlast = 4'(last);
    start = 1'b1;
    stop_req = stop_now;
    c0 = cyc + 1;
    plan(c0, dv, pe, po, ts, last, nframes, endc, last_s);
    nb = 1 + DW + pe + 1 + ts;
    stop_at = last_s + int'($urandom_range(0, nb * (dv + 1) - 1));
    tick(1);
    start = 1'b0;
    stop_req = 1'b0;
    bdiv = 12'($urandom_range(0, 15));
    pen = 1'($urandom);
    podd = 1'($urandom);
    two = 1'($urandom);
    rep = 1'($urandom);
    mlast = 4'($urandom);
    while (cyc < endc + 2) begin
      stop_req = stop_mid && (cyc == stop_at);
      start = poke && (cyc < endc) && ($urandom_range(0, 5) == 0);
      tick(1);
    end
    start = 1'b0;
    stop_req = 1'b0;
  endtask

  initial begin
    int c0, endc, last_s;
    int dv, pe, po, ts, rp, last, nf, mode;
    bit sm, sn;
    rst = 1'b1;
    bdiv = '0; pen = 0; podd = 0; two = 0; rep = 0; mlast = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stop_req = 0;
    bdiv5 = '0; mlast5 = '0; wr5_en = 0; wr5_addr = '0; wr5_data = '0; start5 = 0;
    tick(2);
    mon_en = 1'b1;
    rst = 1'b0;
    tick(1);
    for (int a = 0; a < 16; a++) wr_buf(a, 8'($urandom));

    // Two-character greeting, 8N1, 4-clock bits
    wr_buf(0, 8'h48);
    wr_buf(1, 8'h69);
    run_msg(3, 0, 0, 0, 0, 1, 2, 1'b0, 1'b0, 1'b0);

    // Parity on 0x07, then two stop bits between frames
    wr_buf(0, 8'h07);
    run_msg(2, 1, 0, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_msg(2, 1, 1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_msg(1, 0, 0, 1, 0, 1, 2, 1'b0, 1'b0, 1'b0);

    // Repeat over 3 chars, abort during second pass frame 1
    run_msg(1, 0, 0, 0, 1, 2, 5, 1'b1, 1'b0, 1'b0);

    // start while busy ignored; start together with stop_req sends one frame
    run_msg(2, 1, 0, 0, 0, 2, 3, 1'b0, 1'b0, 1'b1);
    run_msg(1, 0, 0, 0, 0, 3, 1, 1'b0, 1'b1, 1'b0);
    run_msg(0, 0, 0, 0, 1, 3, 1, 1'b0, 1'b1, 1'b0);

    // Reset inside a data bit, then restart from index 0
    bdiv = 12'd2; pen = 0; podd = 0; two = 0; rep = 0; mlast = 4'd2;
    start = 1'b1;
    c0 = cyc + 1;
    plan(c0, 2, 0, 0, 0, 2, 3, endc, last_s);
    tick(1);
    start = 1'b0;
    while (cyc < c0 + 1 + 3 * 3 + 1) tick(1);
    rst = 1'b1;
    flush_at = cyc + 1;
    tick(2);
    rst = 1'b0;
    tick(2);
    run_msg(2, 0, 0, 0, 0, 2, 3, 1'b0, 1'b0, 1'b0);

    // 5-bit instance, 1-clock bits; writes during LOAD and SEND must not leak in
    wr5(0, 5'h15);
    wr5(1, 5'h0A);
    bdiv5 = '0;
    mlast5 = 4'd1;
    start5 = 1'b1;
    c0 = cyc + 1;
    e5_start = c0 + 1;
    push5(5'h15);
    e5q.push_back(1'b1);
    push5(5'h0A);
    e5_done = c0 + 16;
    tick(1);
    start5 = 1'b0;
    wr5_en = 1'b1;
    wr5_addr = '0;
    wr5_data = 5'h1F;
    tick(1);
    wr5_data = 5'h03;
    tick(1);
    wr5_en = 1'b0;
    while (cyc < e5_done + 2) tick(1);
    mlast5 = '0;
    start5 = 1'b1;
    c0 = cyc + 1;
    e5_start = c0 + 1;
    push5(5'h03);
    e5_done = c0 + 8;
    tick(1);
    start5 = 1'b0;
    while (cyc < e5_done + 2) tick(1);

    // Randomised messages
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) wr_buf(int'($urandom_range(0, 3)), 8'($urandom));
      dv = int'($urandom_range(0, 3));
      pe = int'($urandom_range(0, 1));
      po = int'($urandom_range(0, 1));
      ts = int'($urandom_range(0, 1));
      last = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      rp = 0;
      sm = 1'b0;
      sn = 1'b0;
      nf = last + 1;
      case (mode)
        1: begin nf = int'($urandom_range(1, last + 1)); sm = 1'b1; end
        2: begin rp = 1; nf = int'($urandom_range(1, 3 * (last + 1))); sm = 1'b1; end
        3: begin nf = 1; sn = 1'b1; rp = int'($urandom_range(0, 1)); end
        default: ;
      endcase
      run_msg(dv, pe, po, ts, rp, last, nf, sm, sn, 1'($urandom));
    end

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
